// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states, skip conditions and ALU ops.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_ILL0     = 4'h0,
      OP_LOAD     = 4'h1,
      OP_STORE    = 4'h2,
      OP_ADD      = 4'h3,
      OP_SUBT     = 4'h4,
      OP_ILL5     = 4'h5,
      OP_OUTPUT   = 4'h6,
      OP_HALT     = 4'h7,
      OP_SKIPCOND = 4'h8,
      OP_JUMP     = 4'h9,
      OP_CLEAR    = 4'hA,
      OP_ADDI     = 4'hB,
      OP_JUMPI    = 4'hC,
      OP_ILLD     = 4'hD,
      OP_ILLE     = 4'hE,
      OP_ILLF     = 4'hF
   } opcode_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_FETCH_WAIT,
      S_DECODE,
      S_IND_RD,
      S_IND_WAIT,
      S_OPR_RD,
      S_OPR_WAIT,
      S_EXEC,
      S_STORE,
      S_HALT
   } state_e;

   localparam logic [1:0] SKIP_NEG  = 2'b00;
   localparam logic [1:0] SKIP_ZERO = 2'b01;
   localparam logic [1:0] SKIP_POS  = 2'b10;

   typedef enum logic [1:0] {
      ALU_PASS,
      ALU_ADD,
      ALU_SUB
   } alu_op_e;

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: pass-through, add or subtract, wrapping mod 2^DATA_WIDTH.
module acc_alu
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  alu_op_e               op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
   always_comb begin
      y = b;
      unique case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         default: y = b;
      endcase
   end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core driving a single-port synchronous RAM.
// DATA_WIDTH must be at least ADDR_WIDTH+4 so opcode and operand fields do not overlap.
module acc_cpu_core
   import cpu_pkg::*;
#(
   parameter int                      DATA_WIDTH = 16,
   parameter int                      ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  halted,
   output logic                  illegal
);

   state_e                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] mar;
   logic [DATA_WIDTH-1:0] ac;
   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] mbr;

   opcode_e               opcode;
   logic [ADDR_WIDTH-1:0] x;
   logic [1:0]            cond;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  take_skip;
   alu_op_e               alu_op;
   logic [DATA_WIDTH-1:0] alu_y;

   assign opcode = opcode_e'(ir[DATA_WIDTH-1:DATA_WIDTH-4]);
   assign x      = ir[ADDR_WIDTH-1:0];
   assign cond   = x[ADDR_WIDTH-1:ADDR_WIDTH-2];
   assign pc_inc = pc + ADDR_WIDTH'(1);

   always_comb begin
      take_skip = 1'b0;
      unique case (cond)
         SKIP_NEG:  take_skip = ac[DATA_WIDTH-1];
         SKIP_ZERO: take_skip = (ac == '0);
         SKIP_POS:  take_skip = !ac[DATA_WIDTH-1] && (ac != '0);
         default:   take_skip = 1'b0;
      endcase
   end

   always_comb begin
      alu_op = ALU_PASS;
      unique case (opcode)
         OP_ADD, OP_ADDI: alu_op = ALU_ADD;
         OP_SUBT:         alu_op = ALU_SUB;
         default:         alu_op = ALU_PASS;
      endcase
   end

   acc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op (alu_op),
      .a  (ac),
      .b  (mbr),
      .y  (alu_y)
   );

   // Memory strobes decode straight from state so an async reset drops them in the same cycle.
   always_comb begin
      mem_addr = mar;
      unique case (state)
         S_FETCH:          mem_addr = pc;
         S_IND_RD, S_STORE: mem_addr = x;
         S_OPR_RD:         mem_addr = mar;
         default:          mem_addr = mar;
      endcase
   end

   assign mem_re    = (state == S_FETCH) || (state == S_IND_RD) || (state == S_OPR_RD);
   assign mem_we    = (state == S_STORE);
   assign mem_wdata = (state == S_STORE) ? ac : '0;
   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         mar       <= '0;
         ac        <= '0;
         ir        <= '0;
         mbr       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state   <= S_FETCH;
                  illegal <= 1'b0;
               end
            end
            S_FETCH: state <= S_FETCH_WAIT;
            S_FETCH_WAIT: begin
               ir    <= mem_rdata;
               pc    <= pc_inc;
               state <= S_DECODE;
            end
            S_DECODE: begin
               unique case (opcode)
                  OP_LOAD, OP_ADD, OP_SUBT: begin
                     mar   <= x;
                     state <= S_OPR_RD;
                  end
                  OP_STORE:          state <= S_STORE;
                  OP_ADDI, OP_JUMPI: state <= S_IND_RD;
                  OP_OUTPUT: begin
                     out_data  <= ac;
                     out_valid <= 1'b1;
                     state     <= S_FETCH;
                  end
                  OP_HALT: state <= S_HALT;
                  OP_SKIPCOND: begin
                     if (take_skip) pc <= pc_inc;
                     state <= S_FETCH;
                  end
                  OP_JUMP: begin
                     pc    <= x;
                     state <= S_FETCH;
                  end
                  OP_CLEAR: begin
                     ac    <= '0;
                     state <= S_FETCH;
                  end
                  default: begin
                     illegal <= 1'b1;
                     state   <= S_HALT;
                  end
               endcase
            end
            S_IND_RD: state <= S_IND_WAIT;
            S_IND_WAIT: begin
               if (opcode == OP_JUMPI) begin
                  pc    <= mem_rdata[ADDR_WIDTH-1:0];
                  state <= S_FETCH;
               end else begin
                  mar   <= mem_rdata[ADDR_WIDTH-1:0];
                  state <= S_OPR_RD;
               end
            end
            S_OPR_RD: state <= S_OPR_WAIT;
            S_OPR_WAIT: begin
               mbr   <= mem_rdata;
               state <= S_EXEC;
            end
            S_EXEC: begin
               ac    <= alu_y;
               state <= S_FETCH;
            end
            S_STORE: state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Synthesizable, parametrised accumulator CPU core (MARIE-style ISA) replacing the behavioural fetch/decode/execute loop used in simulation. It drives a single-port synchronous RAM through separate read/write data buses and runs a multi-cycle FSM. Compared with the earlier loop it adds indirect addressing, signed skip conditions, an output port, start/halt control and illegal-opcode trapping. Sits between the program RAM and the system-level testbench/IO.

Parameters:
DATA_WIDTH, 16, word/AC/IR width; must be >= ADDR_WIDTH+4
ADDR_WIDTH, 12, memory address width; PC/MAR width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin/resume execution from IDLE or HALT
mem_addr  out  ADDR_WIDTH  RAM address (MAR)
mem_re  out  1  RAM read strobe; rdata valid the following cycle
mem_we  out  1  RAM write strobe, one cycle
mem_wdata  out  DATA_WIDTH  RAM write data (AC)
mem_rdata  in  DATA_WIDTH  RAM read data
out_data  out  DATA_WIDTH  Output-instruction data
out_valid  out  1  one-cycle pulse with out_data
busy  out  1  high in any state other than IDLE/HALT
halted  out  1  high in HALT
illegal  out  1  sticky; set on illegal opcode, cleared by reset or start

Behaviour:
- Reset is asynchronous and active-low (rst_n=0): state=IDLE, PC=RESET_PC, AC=IR=MBR=MAR=0, all outputs 0. A reset asserted mid-instruction takes effect immediately; mem_we drops in that same cycle and no partial write completes.
- Instruction format: opcode=IR[DW-1:DW-4]; operand X=IR[AW-1:0]; skip condition C=X[AW-1:AW-2].
- FSM states: IDLE, FETCH, FETCH_WAIT, DECODE, IND_RD, IND_WAIT, OPR_RD, OPR_WAIT, EXEC, STORE, HALT.
- IDLE/HALT: start=1 -> FETCH; clears illegal. PC is kept, so a resume continues after the Halt instruction.
- FETCH: mem_addr=PC, mem_re=1.
- FETCH_WAIT: IR<=mem_rdata; PC<=PC+1 mod 2^AW (0x..FFF wraps to 0).
- DECODE actions by opcode:
  - 1 Load / 3 Add / 4 Subt -> OPR_RD.
  - 2 Store -> STORE.
  - B AddI / C JumpI -> IND_RD.
  - 6 Output: out_data<=AC, out_valid pulse -> FETCH.
  - 7 Halt -> HALT.
  - 8 Skipcond, AC signed. C=00: skip if AC<0. C=01: skip if AC==0. C=10: skip if AC>0. C=11: never skip. Skip means PC+1 wraps. -> FETCH.
  - 9 Jump: PC<=X -> FETCH.
  - A Clear: AC<=0 -> FETCH.
  - 0, 5, D, E, F: illegal<=1 -> HALT. No memory access.
- IND_RD: mem_addr=X, mem_re=1. IND_WAIT: AddI sets MAR<=mem_rdata[AW-1:0] -> OPR_RD; JumpI sets PC<=mem_rdata[AW-1:0] -> FETCH.
- OPR_RD: mem_addr=MAR (X, or the indirect pointer), mem_re=1. OPR_WAIT: MBR<=mem_rdata.
- EXEC: Load AC<=MBR; Add/AddI AC<=AC+MBR; Subt AC<=AC-MBR. All arithmetic wraps mod 2^DW with no flags. -> FETCH.
- STORE: mem_addr=X, mem_wdata=AC, mem_we=1 for exactly one cycle -> FETCH.
- Cycle counts from FETCH entry to next FETCH:
  - Load, Add, Subt: 6
  - AddI: 8
  - JumpI: 5
  - Store: 4
  - Jump, Clear, Skipcond, Output: 3
  - Halt: 3 to halted=1
- mem_re and mem_we are never asserted together. start is ignored while busy.

Decomposition:
- Shared package cpu_pkg holds: opcode enum (4-bit), FSM state enum, skip-condition constants (SKIP_NEG/ZERO/POS), and the ALU op enum.
- One sub-module, acc_alu, parametrised by DATA_WIDTH: combinational pass/add/sub selected by the ALU op. Register file, PC and FSM stay in acc_cpu_core.

Test Plan (DW=16, AW=12, RESET_PC=0, 1-cycle sync RAM model):
1. Program 0x1100,0x3101,0x2102,0x7000 with mem[0x100]=5, mem[0x101]=7, then pulse start -> mem[0x102]=0x000C, halted=1, PC=0x004, halted rises 19 cycles after start.
2. AC=3, Subt mem=5, then 0x8000 -> AC=0xFFFE and the next instruction is skipped; repeat with 0x8800 (C=10) -> no skip.
3. Multiply loop 3x4 using Load/Add/Subt/Skipcond 0x8400/Jump/Output -> single out_valid pulse with out_data=0x000C, then halted.
4. mem[0x020]=0x0030, mem[0x030]=9, AC=1: 0xB020 -> AC=0x000A in 8 cycles; 0xC020 -> next fetch address 0x030.
5. Opcode 0xF000 -> illegal=1, halted=1, no mem_we; a start pulse clears illegal and resumes at the following address.
6. Jump 0xFFF with mem[0xFFF]=0xA000 -> PC wraps to 0x000. Drop rst_n during STORE -> mem_we=0 immediately and all outputs at reset values.
